// File: rtl/iob_merge_rr.sv
// N-master to 1-slave native-bus merge with round-robin arbitration.
// One transaction is in flight at a time; the response is steered back to the granted master.

module iob_merge_rr_lane #(
  parameter int RESP_W = 33
) (
  input  logic              sel,
  input  logic [RESP_W-1:0] s_resp,
  output logic [RESP_W-1:0] resp
);
  assign resp = sel ? s_resp : '0;
endmodule

module iob_merge_rr #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W    = DATA_W + 1,
  localparam int GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);

  typedef enum logic {IDLE, BUSY} fsm_t;

  fsm_t                 fsm;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        prio;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        idx;
  logic                 any;
  logic [N_MASTERS-1:0] valid;
  logic [REQ_W-1:0]     req_a [N_MASTERS];
  logic [REQ_W-1:0]     gr;

  genvar i;
  generate
    for (i = 0; i < N_MASTERS; i++) begin : g_lane
      assign req_a[i] = m_req[i*REQ_W +: REQ_W];
      assign valid[i] = req_a[i][REQ_W-1];
      iob_merge_rr_lane #(.RESP_W(RESP_W)) u_lane (
        .sel    ((fsm == BUSY) && (grant == GW'(i))),
        .s_resp (s_resp),
        .resp   (m_resp[i*RESP_W +: RESP_W])
      );
    end
  endgenerate

  // First valid master scanning upward from prio, wrapping at N_MASTERS.
  always_comb begin
    any  = 1'b0;
    pick = prio;
    idx  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = GW'((int'(prio) + k) % N_MASTERS);
      if (!any && valid[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

  assign gr    = req_a[grant];
  assign s_req = (fsm == BUSY) ? {1'b1, gr[REQ_W-2:0]} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      grant <= '0;
      prio  <= '0;
    end else begin
      case (fsm)
        IDLE: if (any) begin
          grant <= pick;
          fsm   <= BUSY;
        end
        BUSY: if (s_resp[0]) begin
          fsm  <= IDLE;
          prio <= GW'((int'(grant) + 1) % N_MASTERS);
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
